// File: rtl/sd_source.sv
// sd_source: BT.656 525/59.94 4:2:2 test-pattern source with timing codes and mode-selected active video
module sd_source (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [7:0] MODE_SELECT_8B,
  output logic       o_itu_656_clk,
  output logic [7:0] o_itu_656_data_8b
);
  localparam logic [23:0] bar_ycc [8] = '{24'hB48080, 24'hA22C8E, 24'h839C2C, 24'h70483A,
                                          24'h54B8C6, 24'h4164D4, 24'h23D472, 24'h108080};
  logic [10:0] h_cnt, w, p;
  logic [9:0]  line;
  logic [7:0]  mode, xy, sync_word, word;
  logic [23:0] ycc;
  logic [2:0]  bar;
  logic        f, v, hb, sync;
  assign o_itu_656_clk = ~clk_in;
  always_comb begin
    f = (line < 10'd4) || (line > 10'd265);
    v = (line <= 10'd19) || (line >= 10'd264 && line <= 10'd282);
    hb = h_cnt < 11'd272;
    xy = {1'b1, f, v, hb, v ^ hb, f ^ hb, f ^ v, f ^ v ^ hb};
    w = h_cnt - 11'd276;
    p = {1'b0, w[10:1]};
    bar = 3'(p / 11'd90);
    ycc = mode == 8'd0 ? bar_ycc[bar] :
          mode == 8'd1 ? 24'h108080 :
          mode == 8'd2 ? 24'hEB8080 :
          mode == 8'd3 ? 24'h515AF0 :
          mode == 8'd4 ? 24'h913622 :
          mode == 8'd5 ? 24'h29F06E :
                         {8'd16 + p[9:2], 16'h8080};
    sync = h_cnt < 11'd4 || (h_cnt >= 11'd272 && h_cnt < 11'd276);
    sync_word = h_cnt[1:0] == 2'd0 ? 8'hFF : h_cnt[1:0] == 2'd3 ? xy : 8'h00;
    // Active words run Cb,Y,Cr,Y; one chroma pair serves two pixels
    word = sync ? sync_word :
           (h_cnt < 11'd276 || v) ? (h_cnt[0] ? 8'h10 : 8'h80) :
           w[0] ? ycc[23:16] : w[1] ? ycc[7:0] : ycc[15:8];
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      h_cnt <= '0;
      line <= 10'd1;
      mode <= '0;
      o_itu_656_data_8b <= 8'h10;
    end else begin
      o_itu_656_data_8b <= word;
      h_cnt <= h_cnt == 11'd1715 ? 11'd0 : h_cnt + 11'd1;
      if (h_cnt == 11'd1715) line <= line == 10'd525 ? 10'd1 : line + 10'd1;
      if (h_cnt == 11'd0) mode <= MODE_SELECT_8B;
    end
  end
endmodule

// File: tb/tb_sd_source.sv
// tb_sd_source: scoreboard bench; expected words queued by stream position and checked as they emerge
module tb_sd_source;
  logic       clk_in = 1'b0;
  logic       rst_in = 1'b1;
  logic [7:0] mode_sel = 8'd0;
  logic       o_itu_656_clk;
  logic [7:0] o_itu_656_data_8b;
  typedef struct {int ln; int h; logic [7:0] exp; string tag;} exp_t;
  exp_t sb[$];
  exp_t e;
  int checks = 0, errors = 0;
  int th = 0, tl = 0, oh = 0, ol = 0;
  bit ov = 1'b0;
  sd_source dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .MODE_SELECT_8B(mode_sel),
    .o_itu_656_clk(o_itu_656_clk),
    .o_itu_656_data_8b(o_itu_656_data_8b)
  );
  always #5 clk_in = ~clk_in;
  // th/tl: position the next edge will emit; oh/ol: position now on the output
  always @(posedge clk_in) begin
    if (rst_in) begin
      th <= 0;
      tl <= 1;
      ov <= 1'b0;
    end else begin
      oh <= th;
      ol <= tl;
      ov <= 1'b1;
      th <= th == 1715 ? 0 : th + 1;
      tl <= th == 1715 ? (tl == 525 ? 1 : tl + 1) : tl;
    end
  end
  always @(posedge clk_in) begin
    #1;
    checks++;
    assert (o_itu_656_clk === 1'b0) else begin errors++; $error("FAIL clk_hi: got %b expected 0", o_itu_656_clk); end
  end
  always @(negedge clk_in) begin
    checks++;
    assert (o_itu_656_clk === 1'b1) else begin errors++; $error("FAIL clk_lo: got %b expected 1", o_itu_656_clk); end
    if (ov) begin
      if ((oh >= 4 && oh < 272) || oh >= 276) begin
        checks++;
        assert (o_itu_656_data_8b !== 8'h00 && o_itu_656_data_8b !== 8'hFF) else begin
          errors++; $error("FAIL payload L%0d H%0d: got %h expected 01..FE", ol, oh, o_itu_656_data_8b);
        end
      end
      if (sb.size() > 0 && sb[0].ln == ol && sb[0].h == oh) begin
        e = sb.pop_front();
        checks++;
        assert (o_itu_656_data_8b === e.exp) else begin
          errors++; $error("FAIL %s L%0d H%0d: got %h expected %h", e.tag, ol, oh, o_itu_656_data_8b, e.exp);
        end
      end
    end
  end
  function automatic void push(int ln, int h, logic [7:0] x, string t);
    sb.push_back('{ln, h, x, t});
  endfunction
  function automatic void push4(int ln, int h, logic [31:0] x, string t);
    for (int i = 0; i < 4; i++) push(ln, h + i, x[31-8*i -: 8], t);
  endfunction
  task automatic go_to(int ln, int h);
    int n = 0;
    while (!(tl == ln && th == h) && n < 60000) begin
      @(negedge clk_in);
      n++;
    end
    checks++;
    assert (tl == ln && th == h) else begin errors++; $error("FAIL timeout: at L%0d H%0d expected L%0d H%0d", tl, th, ln, h); end
  endtask
  initial begin
    repeat (3) @(negedge clk_in);
    checks++;
    assert (o_itu_656_data_8b === 8'h10) else begin errors++; $error("FAIL reset_out: got %h expected 10", o_itu_656_data_8b); end
    push4(1, 0, 32'hFF0000F1, "eav_l1");
    push(1, 4, 8'h80, "hblank_even");
    push(1, 5, 8'h10, "hblank_odd");
    push(1, 271, 8'h10, "hblank_end");
    push4(1, 272, 32'hFF0000EC, "sav_l1");
    push(1, 276, 8'h80, "vblank_act0");
    push(1, 277, 8'h10, "vblank_act1");
    push(1, 1715, 8'h10, "vblank_last");
    push(3, 3, 8'hF1, "eav_l3");
    push(4, 3, 8'hB6, "eav_l4");
    push(4, 275, 8'hAB, "sav_l4");
    push(19, 3, 8'hB6, "eav_l19");
    push(19, 275, 8'hAB, "sav_l19");
    push(19, 277, 8'h10, "vblank_l19");
    push(20, 3, 8'h9D, "eav_l20");
    push(20, 275, 8'h80, "sav_l20");
    push4(20, 276, 32'h80B480B4, "bars_white");
    push(20, 456, 8'h2C, "bars_yel_cb");
    push(20, 457, 8'hA2, "bars_yel_y");
    push(20, 1000, 8'hB8, "no_tear");
    push4(20, 1534, 32'h72238010, "bars_blu_blk");
    push4(21, 276, 32'h80EB80EB, "mode2_white");
    push4(22, 276, 32'hF0296E29, "mode5_start");
    push4(22, 1712, 32'hF0296E29, "mode5_end");
    push(23, 277, 8'h10, "ramp_p0");
    push(23, 285, 8'h11, "ramp_p4");
    push(23, 1713, 8'hC3, "ramp_p718");
    push(23, 1715, 8'hC3, "ramp_p719");
    push4(24, 276, 32'h5A51F051, "mode3_red");
    push4(25, 276, 32'h36912291, "mode4_green");
    rst_in = 1'b0;
    go_to(20, 600); mode_sel = 8'd2;
    go_to(21, 600); mode_sel = 8'd5;
    go_to(22, 600); mode_sel = 8'd8;
    go_to(23, 600); mode_sel = 8'd3;
    go_to(24, 600); mode_sel = 8'd4;
    go_to(25, 1000);
    rst_in = 1'b1;
    @(negedge clk_in);
    checks++;
    assert (o_itu_656_data_8b === 8'h10) else begin errors++; $error("FAIL midline_rst: got %h expected 10", o_itu_656_data_8b); end
    repeat (2) @(negedge clk_in);
    push4(1, 0, 32'hFF0000F1, "eav_restart");
    push4(1, 272, 32'hFF0000EC, "sav_restart");
    push(2, 3, 8'hF1, "eav_l2");
    rst_in = 1'b0;
    go_to(2, 10);
    checks++;
    assert (sb.size() == 0) else begin errors++; $error("FAIL unmatched: got %0d pending expected 0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
